// File: rtl/shared_ram_pkg.sv
// shared_ram_pkg: default sizing, registered request record and parity helper for shared_data_ram
package shared_ram_pkg;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);
  localparam int DEF_CORES = 4;
  localparam int DEF_ID_WIDTH = $clog2(DEF_CORES);
  typedef struct packed {
    logic                      valid;
    logic                      wr_en;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_WIDTH-1:0]      data;
    logic [DEF_ID_WIDTH-1:0]   core_id;
  } req_t;
  function automatic logic even_parity(input logic [DEF_WIDTH-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; priority starts just after the last accepted requester
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int LW = $clog2(N);
  logic [LW-1:0] last, pick, idx;
  int s;
  // scan lowest priority first so the highest-priority hit overwrites earlier ones
  always_comb begin
    gnt = '0;
    pick = '0;
    idx = '0;
    s = 0;
    for (int i = N; i >= 1; i--) begin
      s = int'(last) + i;
      s = s >= N ? s - N : s;
      idx = LW'(s);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        pick = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) last <= LW'(N - 1);
    else if (|gnt) last <= pick;
endmodule

// File: rtl/shared_data_ram.sv
// shared_data_ram: single-port data RAM shared by CORES requesters, registered request then access.
// Define RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on rspErr.
module shared_data_ram
  import shared_ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CORES = DEF_CORES
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [CORES-1:0]                 reqValid,
  input  logic [CORES-1:0]                 reqWrEn,
  input  logic [CORES-1:0][ADDR_WIDTH-1:0] reqAddr,
  input  logic [CORES-1:0][WIDTH-1:0]      reqData,
  output logic [CORES-1:0]                 reqReady,
  output logic [CORES-1:0]                 rspValid,
  output logic [WIDTH-1:0]                 rspData,
  output logic                             rspErr
);
  localparam int CW = $clog2(CORES);
`ifdef RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  logic [CORES-1:0] gnt;
  logic [CW-1:0] id;
  req_t req_d, req_q;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_word, wr_word;
  logic in_range, rd;
  rr_arbiter #(.N(CORES)) u_arb (
    .clk (clk),
    .rstN(rstN),
    .req (reqValid),
    .gnt (gnt)
  );
  assign reqReady = gnt;
  always_comb begin
    id = '0;
    for (int c = 0; c < CORES; c++) id = gnt[c] ? CW'(c) : id;
  end
  always_comb begin
    req_d.valid = |gnt;
    req_d.wr_en = reqWrEn[id];
    req_d.addr = reqAddr[id];
    req_d.data = reqData[id];
    req_d.core_id = id;
  end
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) req_q <= '0;
    else req_q <= req_d;
  // only reachable false when DEPTH is not a power of two
  assign in_range = int'(req_q.addr) < DEPTH;
  assign rd = req_q.valid && !req_q.wr_en;
  assign rd_word = in_range ? mem[req_q.addr] : '0;
`ifdef RAM_PARITY_EN
  assign wr_word = {even_parity(req_q.data), req_q.data};
`else
  assign wr_word = req_q.data;
`endif
  always_ff @(posedge clk)
    if (req_q.valid && req_q.wr_en && in_range) mem[req_q.addr] <= wr_word;
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      rspValid <= '0;
      rspData <= '0;
    end else begin
      rspValid <= rd ? CORES'(1) << req_q.core_id : '0;
      rspData <= rd ? rd_word[WIDTH-1:0] : rspData;
    end
`ifdef RAM_PARITY_EN
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) rspErr <= 1'b0;
    else rspErr <= rd && in_range && (^rd_word);
`else
  assign rspErr = 1'b0;
`endif
endmodule

// File: doc/shared_data_ram.md
# shared_data_ram

Shared single-port data memory for the multicore processor, serving CORES requesters through a round-robin arbiter with valid/ready request and valid-only response handshakes. Each accepted request is registered before the memory access, which is the same registered-input discipline as the existing single-core RAM, now generalised to N cores. Cores issue loads and stores here instead of owning private RAM; the block accepts one request per cycle and returns read data with fixed latency.

## Interface
- WIDTH, 12, data word width in bits
- DEPTH, 256, number of words
- ADDR_WIDTH, $clog2(DEPTH), address width
- CORES, 4, number of requesting cores (≥2)
- clk  input  1  single clock; all state updates on posedge
- rstN  input  1  asynchronous, active-low reset
- reqValid  input  [CORES]  core c presents a request
- reqWrEn  input  [CORES]  1 = write, 0 = read
- reqAddr  input  [CORES][ADDR_WIDTH]  word address
- reqData  input  [CORES][WIDTH]  write data
- reqReady  output  [CORES]  one-hot or zero; request of core c accepted this cycle
- rspValid  output  [CORES]  one-hot or zero; read data for core c valid this cycle
- rspData  output  [WIDTH]  read data shared by all cores, qualified by rspValid
- rspErr  output  1  parity error on current response (only with RAM_PARITY_EN; tied 0 otherwise)

## Operation
- Arbitration: combinational over reqValid; priority starts at core (lastGrant+1) mod CORES and wraps. reqReady[c]=1 for the granted core only. lastGrant updates on each accept. Reset lastGrant = CORES-1, so core 0 has first priority.
- Request held stable by the core until reqReady; dropping reqValid before ready is legal (request withdrawn).
- Stage 1 (on accept edge E0): register valid, wrEn, addr, data, core id.
- Stage 2 (edge E1): write → memory[addr] <= data, no response. Read → rspData <= memory[addr], rspValid[id] <= 1 for one cycle.
- No backpressure on responses; the pipeline never stalls. One acceptance per cycle, sustained.
- Write then read of same address back-to-back, from any cores: the read sees new data (write commits at E1, read samples at E2).
- Out-of-range addresses are impossible (DEPTH power of 2 required); for non-power-of-2 DEPTH, address ≥ DEPTH: write ignored, read returns 0.
- Reset: stage registers, rspValid, rspData, rspErr and lastGrant clear to 0 / CORES-1. Memory array is not reset. An in-flight request is discarded; no write commits and no response is issued.

## Timing
- reqReady: combinational from reqValid and lastGrant, same cycle.
- Read latency: rspValid high for exactly one cycle, 2 edges after the accept edge (E0 accept, E1 data registered, valid visible in the cycle after E1).
- Write visible to any read accepted at or after E1.
- Reset values: reqReady=0 while reqValid=0; rspValid=0; rspData=0; rspErr=0.

## Configuration
- RAM_PARITY_EN defined: memory stores WIDTH+1 bits with even parity computed at stage 2 on write; read checks parity, and rspErr=1 with rspValid on mismatch. rspData is still returned unmodified.
- Undefined: memory is WIDTH bits and rspErr is constant 0. The port always exists.

## Structure
- Package shared_ram_pkg: parameter defaults, typedef of the registered request struct (valid, wrEn, addr, data, coreId), parity function.
- Sub-module rr_arbiter (parameter N): reqValid in, one-hot grant out, internal lastGrant register with async active-low reset.

## Test plan
- Core 1 writes 0xABC to addr 5, then core 2 reads addr 5 → rspValid[2] exactly 2 edges after accept, rspData=0xABC.
- All 4 cores assert reads at once after reset, held → grants in order 0,1,2,3 on consecutive cycles; 4 responses on consecutive cycles with matching rspValid bits.
- Core 0 holds continuous requests while core 3 requests once → core 3 granted within CORES cycles; no starvation.
- Write 0x123 at addr 0xFF accepted at E0, read of 0xFF accepted at E1 → read returns 0x123.
- Read accepted, then rstN pulsed low before E1 → no rspValid, and outputs stay 0. Write accepted then reset before E1 → address keeps its old value.
- RAM_PARITY_EN: write 0x00F, flip one stored bit by backdoor, read → rspErr=1 with rspValid; unflipped word → rspErr=0.
